// File: rtl/alu_access_arbiter.sv
// Two-requester round-robin front end for a shared, trojan-protected ALU.
// One operation in flight; repeated mitigation events lock a requester out.
module alu_access_arbiter #(
  parameter int unsigned LOCK_THRESH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic [3:0] rsp0_result,
  output logic       rsp0_flag,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  output logic [3:0] rsp1_result,
  output logic       rsp1_flag,
  input  logic       rsp1_ready,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_opcode,
  input  logic [3:0] alu_result,
  input  logic       alu_mitigation,
  input  logic [1:0] clear_lock,
  output logic [1:0] locked
);

  localparam logic [3:0] Thresh = 4'(LOCK_THRESH);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      a_q, b_q, res_q;
  logic [1:0]      op_q;
  logic            gnt_q, last_q, flag_q;
  logic [1:0][3:0] strike_q;

  logic [1:0] elig, ready, rsp_valid, rsp_ready;
  logic       accept, gnt_sel, capture;
  logic [3:0] sel_a, sel_b;
  logic [1:0] sel_op;

  assign locked[0] = (strike_q[0] == Thresh);
  assign locked[1] = (strike_q[1] == Thresh);

  assign elig      = {req1_valid, req0_valid} & ~locked;
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  // On a tie, serve whoever was not granted last.
  assign gnt_sel   = (&elig) ? ~last_q : elig[1];
  assign sel_a     = gnt_sel ? req1_a  : req0_a;
  assign sel_b     = gnt_sel ? req1_b  : req0_b;
  assign sel_op    = gnt_sel ? req1_op : req0_op;
  assign capture   = (state_q == StExec);

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    ready      = 2'b00;
    rsp_valid  = 2'b00;
    alu_a      = 4'd0;
    alu_b      = 4'd0;
    alu_opcode = 2'd0;
    case (state_q)
      StIdle: begin
        if (|elig) begin
          accept         = 1'b1;
          ready[gnt_sel] = rst_n;
          state_d        = StExec;
        end
      end
      StExec: begin
        alu_a      = a_q;
        alu_b      = b_q;
        alu_opcode = op_q;
        state_d    = StResp;
      end
      StResp: begin
        alu_a            = a_q;
        alu_b            = b_q;
        alu_opcode       = op_q;
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req0_ready  = ready[0];
  assign req1_ready  = ready[1];
  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_result = rsp_valid[0] ? res_q : 4'd0;
  assign rsp1_result = rsp_valid[1] ? res_q : 4'd0;
  assign rsp0_flag   = rsp_valid[0] & flag_q;
  assign rsp1_flag   = rsp_valid[1] & flag_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      op_q     <= 2'd0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      res_q    <= 4'd0;
      flag_q   <= 1'b0;
      strike_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        op_q   <= sel_op;
        gnt_q  <= gnt_sel;
        last_q <= gnt_sel;
      end
      if (capture) begin
        res_q  <= alu_result;
        flag_q <= alu_mitigation;
      end
      for (int n = 0; n < 2; n++) begin
        if (clear_lock[n]) begin
          strike_q[n] <= 4'd0;
        end else if (capture && alu_mitigation && (gnt_q == n[0]) &&
                     (strike_q[n] < Thresh)) begin
          strike_q[n] <= strike_q[n] + 4'd1;
        end
      end
    end
  end

endmodule
